truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/tts_pkg.sv | 13 +
 rtl/tts_popcount.sv | 18 +
 rtl/truth_table_sweeper.sv | 150 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tts_pkg;

  localparam int unsigned ERR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tts_popcount.sv
// Combinational population count of the per-channel mismatch vector.
module tts_popcount #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]          bits,
  output logic [$clog2(N_CH):0]    count
);

  localparam int unsigned CW = $clog2(N_CH) + 1;

  always_comb begin
    count = '0;
    for (int i = 0; i < N_CH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector into a DUT, holds it HOLD cycles, then compares
// each output channel against an expected truth table and accumulates errors.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int unsigned N_IN = 3,
  parameter int unsigned N_CH = 4,
  parameter int unsigned HOLD = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       abort,
  input  logic [N_CH*(2**N_IN)-1:0]  exp_tbl,
  input  logic [N_CH-1:0]            dut_y,
  output logic [N_IN-1:0]            vec,
  output logic                       busy,
  output logic                       done,
  output logic [N_CH-1:0]            fail_ch,
  output logic [ERR_W-1:0]           err_count,
  output logic [N_IN-1:0]            first_vec,
  output logic                       first_valid
);

  localparam int unsigned NV     = 2**N_IN;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned PC_W   = $clog2(N_CH) + 1;
  localparam int unsigned SUM_W  = ERR_W + 1;
  localparam logic [N_IN-1:0]   VEC_LAST  = N_IN'(NV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  state_t              state, state_d;
  logic [N_IN-1:0]     vec_d, first_vec_d;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic                mode_q, mode_d;
  logic                busy_d, done_d, first_valid_d;
  logic [N_CH-1:0]     fail_d, mismatch;
  logic [ERR_W-1:0]    err_d;
  logic [PC_W-1:0]     mis_cnt;
  logic [SUM_W-1:0]    err_sum;

  // Each channel's expected row is 2^N_IN bits wide, indexed by the live vector.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [NV-1:0] row;
    assign row         = exp_tbl[c*NV +: NV];
    assign mismatch[c] = dut_y[c] ^ row[vec];
  end

  tts_popcount #(.N_CH(N_CH)) u_popcount (
    .bits  (mismatch),
    .count (mis_cnt)
  );

  // One spare bit catches overflow for saturation.
  assign err_sum = {1'b0, err_count} + SUM_W'(mis_cnt);

  always_comb begin
    state_d       = state;
    vec_d         = vec;
    hold_d        = hold_cnt;
    mode_d        = mode_q;
    done_d        = 1'b0;
    fail_d        = fail_ch;
    err_d         = err_count;
    first_vec_d   = first_vec;
    first_valid_d = first_valid;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          fail_d        = '0;
          err_d         = '0;
          first_vec_d   = '0;
          first_valid_d = 1'b0;
          vec_d         = '0;
          hold_d        = '0;
          mode_d        = mode;
          state_d       = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          hold_d  = '0;
          state_d = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_d  = '0;
          state_d = CHECK;
        end else begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          fail_d = fail_ch | mismatch;
          err_d  = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
          if ((|mismatch) && !first_valid) begin
            first_vec_d   = vec;
            first_valid_d = 1'b1;
          end
          if (vec == VEC_LAST) begin
            done_d = 1'b1;
            if (mode_q) begin
              vec_d   = '0;
              state_d = DRIVE;
            end else begin
              state_d = DONE;
            end
          end else begin
            vec_d   = vec + N_IN'(1);
            state_d = DRIVE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE) || (state_d == CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vec         <= '0;
      hold_cnt    <= '0;
      mode_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail_ch     <= '0;
      err_count   <= '0;
      first_vec   <= '0;
      first_valid <= 1'b0;
    end else begin
      state       <= state_d;
      vec         <= vec_d;
      hold_cnt    <= hold_d;
      mode_q      <= mode_d;
      busy        <= busy_d;
      done        <= done_d;
      fail_ch     <= fail_d;
      err_count   <= err_d;
      first_vec   <= first_vec_d;
      first_valid <= first_valid_d;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: directed scenarios plus random stimulus,
// checked every cycle against a time-indexed behavioural model.
module tb_truth_table_sweeper;

  localparam int N_IN = 3;
  localparam int N_CH = 2;
  localparam int HOLD = 1;
  localparam int NV   = 8;
  localparam int PASS = NV * (HOLD + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_tbl = 16'hFE80;
  logic [1:0]  dut_y;
  logic [2:0]  vec;
  logic        busy, done;
  logic [1:0]  fail_ch;
  logic [15:0] err_count;
  logic [2:0]  first_vec;
  logic        first_valid;

  logic [1:0]  fmask [NV];

  int total = 0;
  int bad   = 0;

  // Model state: sweep progress is just elapsed cycles since start.
  bit       m_active = 0;
  bit       m_in_done = 0;
  bit       m_mode = 0;
  bit       m_done = 0;
  int       m_t = 0;
  int       m_vec = 0;
  logic [1:0] m_fail = 2'b00;
  int       m_err = 0;
  int       m_fv = 0;
  bit       m_fvalid = 0;

  truth_table_sweeper #(.N_IN(N_IN), .N_CH(N_CH), .HOLD(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .abort       (abort),
    .exp_tbl     (exp_tbl),
    .dut_y       (dut_y),
    .vec         (vec),
    .busy        (busy),
    .done        (done),
    .fail_ch     (fail_ch),
    .err_count   (err_count),
    .first_vec   (first_vec),
    .first_valid (first_valid)
  );

  always #5 clk = ~clk;

  // Device under sweep: ch0 = AND3, ch1 = OR3, optionally corrupted per vector.
  assign dut_y = {|vec, &vec} ^ fmask[vec];

  function automatic logic model_y(input int v, input int c);
    logic y;
    y = (c == 0) ? (v == NV - 1) : (v != 0);
    return y ^ fmask[v][c];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int pos, v, nmis;
    if (!rst_n) begin
      m_active = 0; m_in_done = 0; m_mode = 0; m_done = 0; m_t = 0;
      m_vec = 0; m_fail = 2'b00; m_err = 0; m_fv = 0; m_fvalid = 0;
      return;
    end
    m_done = 0;
    if (m_active) begin
      if (abort) begin
        m_active = 0;
      end else begin
        pos = m_t % PASS;
        v   = pos / (HOLD + 1);
        if (pos % (HOLD + 1) == HOLD) begin
          nmis = 0;
          for (int c = 0; c < N_CH; c++) begin
            if (model_y(v, c) != exp_tbl[c*NV + v]) begin
              m_fail[c] = 1'b1;
              nmis++;
            end
          end
          if (nmis > 0 && !m_fvalid) begin
            m_fvalid = 1;
            m_fv = v;
          end
          m_err = (m_err + nmis > 65535) ? 65535 : m_err + nmis;
          if (v == NV - 1) begin
            m_done = 1;
            if (!m_mode) begin
              m_active  = 0;
              m_in_done = 1;
            end
          end
        end
        m_t++;
        if (m_active) m_vec = (m_t % PASS) / (HOLD + 1);
      end
    end else if (m_in_done) begin
      m_in_done = 0;
    end else if (start && !abort) begin
      m_active = 1; m_t = 0; m_mode = mode; m_vec = 0;
      m_fail = 2'b00; m_err = 0; m_fv = 0; m_fvalid = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Cycle-by-cycle comparison away from the active edge.
  initial forever begin
    @(negedge clk);
    check("vec",         32'(vec),         32'(m_vec));
    check("busy",        32'(busy),        32'(m_active));
    check("done",        32'(done),        32'(m_done));
    check("fail_ch",     32'(fail_ch),     32'(m_fail));
    check("err_count",   32'(err_count),   32'(m_err));
    check("first_vec",   32'(first_vec),   32'(m_fv));
    check("first_valid", 32'(first_valid), 32'(m_fvalid));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < budget);
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    bit seen_done;
    for (int i = 0; i < NV; i++) fmask[i] = 2'b00;

    // Reset values while rst_n is low
    #20;
    check("rst_vec",   32'(vec),       32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err_count), 32'd0);
    check("rst_fv",    32'(first_valid), 32'd0);

    // Clean single sweep; start issued right as reset lifts
    #3 rst_n = 1'b1;
    exp_tbl = 16'hFE80;
    pulse_start(1'b0);
    wait_done(40, n);
    check("clean_latency", 32'(n + 1), 32'd17);
    check("clean_fail",    32'(fail_ch), 32'd0);
    check("clean_err",     32'(err_count), 32'd0);
    check("clean_fvalid",  32'(first_valid), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("vec_holds_last", 32'(vec), 32'd7);

    // Single flipped expectation: ch1, vector 5
    exp_tbl = 16'hDE80;
    pulse_start(1'b0);
    wait_done(40, n);
    check("flip_fail",   32'(fail_ch), 32'b10);
    check("flip_err",    32'(err_count), 32'd1);
    check("flip_fvec",   32'(first_vec), 32'd5);
    check("flip_fvalid", 32'(first_valid), 32'd1);
    tick();

    // Continuous mode, ch0 wrong everywhere
    exp_tbl = 16'hFE7F;
    pulse_start(1'b1);
    wait_done(40, n);
    check("cont_latency", 32'(n + 1), 32'd17);
    check("cont_err_p1",  32'(err_count), 32'd8);
    check("model_err_p1", 32'(m_err), 32'd8);
    check("cont_fail",    32'(fail_ch), 32'b01);
    wait_done(40, n);
    check("cont_period",  32'(n), 32'd16);
    check("cont_err_p2",  32'(err_count), 32'd16);
    check("cont_fvec",    32'(first_vec), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cont_abort_busy", 32'(busy), 32'd0);
    tick();

    // Abort in CHECK for vector 4; a restart attempt mid-sweep is ignored
    pulse_start(1'b0);
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) begin start = 1'b1; mode = 1'b1; end
      tick();
      start = 1'b0; mode = 1'b0;
    end
    check("pre_abort_vec", 32'(vec), 32'd4);
    check("pre_abort_err", 32'(err_count), 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err",  32'(err_count), 32'd4);
    check("abort_vec",  32'(vec), 32'd4);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      seen_done |= done;
      tick();
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    // start and abort together in idle: stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);

    // Asynchronous reset during DRIVE for vector 6
    pulse_start(1'b0);
    repeat (12) tick();
    check("pre_rst_vec",  32'(vec), 32'd6);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vec",    32'(vec), 32'd0);
    check("arst_busy",   32'(busy), 32'd0);
    check("arst_err",    32'(err_count), 32'd0);
    check("arst_fail",   32'(fail_ch), 32'd0);
    check("arst_fvalid", 32'(first_valid), 32'd0);
    #4 rst_n = 1'b1;
    exp_tbl = 16'hFE80;
    pulse_start(1'b0);
    wait_done(40, n);
    check("post_rst_latency", 32'(n + 1), 32'd17);
    check("post_rst_err",     32'(err_count), 32'd0);
    check("post_rst_fail",    32'(fail_ch), 32'd0);
    tick();

    // Randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) begin
        if ($urandom_range(0, 1) == 1)
          exp_tbl = 16'hFE80 ^ (16'd1 << $urandom_range(0, 15));
        else
          exp_tbl = 16'($urandom);
        for (int i = 0; i < NV; i++)
          fmask[i] = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      end
      start = ($urandom_range(0, 9) == 0);
      mode  = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 59) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; mode = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
